// File: rtl/ysyx_22040237_ifu_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package ysyx_22040237_ifu_pkg;
    localparam int ADDR_W_DEF = 64;
    localparam int INST_W_DEF = 32;
    localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_HALT = 3'd4
    } state_t;
endpackage

// File: rtl/ysyx_22040237_ifu_pc.sv
// PC register: reset value, sequential +4 or redirect load (load wins).
module ysyx_22040237_ifu_pc #(
    parameter int ADDR_W = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_nxt
);
    always_comb begin
        pc_nxt = pc;
        if (load)
            pc_nxt = target;
        else if (inc)
            pc_nxt = pc + ADDR_W'(4);
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else
            pc <= pc_nxt;
    end
endmodule

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: request/response fetch FSM with a one-entry
// instruction buffer, redirect handling, halt and misalignment detection.
module ysyx_22040237_ifu
    import ysyx_22040237_ifu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INST_W = INST_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_resp_valid_i,
    input  logic [INST_W-1:0] imem_resp_data_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              halt_i,
    output logic              misalign_o,
    output logic              halted_o
);
    state_t state, st_n;
    logic kill, kill_n, mis_n;
    logic pc_inc, pc_load, latch;
    logic [ADDR_W-1:0] pc, pc_nxt;

    wire req_hs    = imem_req_valid_o & imem_req_ready_i;
    wire inst_hs   = inst_valid_o & inst_ready_i;
    wire mis_redir = redirect_valid_i && ((redirect_pc_i[1:0] & ALIGN_MASK) != 2'b00);

    ysyx_22040237_ifu_pc #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk    (clk),
        .rst    (rst),
        .inc    (pc_inc),
        .load   (pc_load),
        .target (redirect_pc_i),
        .pc     (pc),
        .pc_nxt (pc_nxt)
    );

    always_comb begin
        st_n    = state;
        kill_n  = kill;
        mis_n   = misalign_o;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        latch   = 1'b0;
        case (state)
            S_IDLE: begin
                if (mis_redir) begin
                    st_n  = S_HALT;
                    mis_n = 1'b1;
                end else begin
                    st_n = S_REQ;
                end
            end
            S_REQ: begin
                if (mis_redir) begin
                    st_n  = S_HALT;
                    mis_n = 1'b1;
                end else if (redirect_valid_i) begin
                    pc_load = 1'b1;
                    if (req_hs) begin
                        kill_n = 1'b1;
                        st_n   = S_WAIT;
                    end
                end else if (req_hs) begin
                    st_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mis_redir) begin
                    st_n  = S_HALT;
                    mis_n = 1'b1;
                end else if (redirect_valid_i) begin
                    pc_load = 1'b1;
                    // Response landing now is the stale one; nothing else is outstanding.
                    if (imem_resp_valid_i) begin
                        kill_n = 1'b0;
                        st_n   = S_REQ;
                    end else begin
                        kill_n = 1'b1;
                    end
                end else if (imem_resp_valid_i) begin
                    if (kill) begin
                        kill_n = 1'b0;
                        st_n   = S_REQ;
                    end else begin
                        latch = 1'b1;
                        st_n  = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (inst_hs && halt_i) begin
                    st_n = S_HALT;
                end else if (mis_redir) begin
                    st_n  = S_HALT;
                    mis_n = 1'b1;
                end else if (redirect_valid_i) begin
                    pc_load = 1'b1;
                    st_n    = S_REQ;
                end else if (inst_hs) begin
                    pc_inc = 1'b1;
                    st_n   = S_REQ;
                end
            end
            S_HALT: st_n = S_HALT;
            default: st_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            kill             <= 1'b0;
            imem_req_valid_o <= 1'b0;
            imem_addr_o      <= '0;
            inst_valid_o     <= 1'b0;
            inst_o           <= '0;
            pc_o             <= '0;
            misalign_o       <= 1'b0;
            halted_o         <= 1'b0;
        end else begin
            state            <= st_n;
            kill             <= kill_n;
            misalign_o       <= mis_n;
            imem_req_valid_o <= (st_n == S_REQ);
            inst_valid_o     <= (st_n == S_HOLD);
            halted_o         <= (st_n == S_HALT);
            imem_addr_o      <= pc_nxt;
            if (latch) begin
                inst_o <= imem_resp_data_i;
                pc_o   <= pc;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Directed scenarios plus randomized traffic checked against a
// transaction-level model of the expected fetch/handover address stream.
module tb_ysyx_22040237_ifu;
    localparam logic [63:0] RPC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid_o, imem_req_ready_i;
    logic [63:0] imem_addr_o;
    logic        imem_resp_valid_i;
    logic [31:0] imem_resp_data_i;
    logic        inst_valid_o, inst_ready_i;
    logic [31:0] inst_o;
    logic [63:0] pc_o;
    logic        redirect_valid_i;
    logic [63:0] redirect_pc_i;
    logic        halt_i, misalign_o, halted_o;

    int n_cmp = 0;
    int n_bad = 0;

    ysyx_22040237_ifu dut (
        .clk(clk), .rst(rst),
        .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
        .imem_addr_o(imem_addr_o), .imem_resp_valid_i(imem_resp_valid_i),
        .imem_resp_data_i(imem_resp_data_i), .inst_valid_o(inst_valid_o),
        .inst_ready_i(inst_ready_i), .inst_o(inst_o), .pc_o(pc_o),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .halt_i(halt_i), .misalign_o(misalign_o), .halted_o(halted_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] memval(input logic [63:0] a);
        return a[31:0] * 32'h9E37_79B1 + 32'h1357;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        imem_req_ready_i = 0; imem_resp_valid_i = 0; imem_resp_data_i = '0;
        inst_ready_i = 0; redirect_valid_i = 0; redirect_pc_i = '0; halt_i = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_reqv"}, {63'b0, imem_req_valid_o}, 64'd0);
        chk({tag, "_addr"}, imem_addr_o, 64'd0);
        chk({tag, "_instv"}, {63'b0, inst_valid_o}, 64'd0);
        chk({tag, "_inst"}, {32'b0, inst_o}, 64'd0);
        chk({tag, "_pco"}, pc_o, 64'd0);
        chk({tag, "_mis"}, {63'b0, misalign_o}, 64'd0);
        chk({tag, "_halt"}, {63'b0, halted_o}, 64'd0);
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1;
        tick(); tick();
        chk_zero("reset");
        rst = 0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        imem_req_ready_i = 0;
        while (!imem_req_valid_o && n < 20) begin
            tick();
            n++;
        end
        if (!imem_req_valid_o) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    // From REQ: accept the request, answer it one cycle later, land in HOLD.
    task automatic fetch(input logic [31:0] d);
        imem_req_ready_i = 1; tick(); imem_req_ready_i = 0;
        imem_resp_valid_i = 1; imem_resp_data_i = d; tick(); imem_resp_valid_i = 0;
    endtask

    task automatic handover();
        inst_ready_i = 1; tick(); inst_ready_i = 0;
    endtask

    initial begin
        int reqs;
        int pend, cnt, handed;
        logic busy;
        logic [63:0] exp_pc, paddr, tgt;

        do_reset();

        // 1: basic fetch
        wait_req("t1");
        chk("t1_addr", imem_addr_o, RPC);
        fetch(32'h0000_0413);
        chk("t1_instv", {63'b0, inst_valid_o}, 64'd1);
        chk("t1_inst", {32'b0, inst_o}, 64'h413);
        chk("t1_pco", pc_o, RPC);

        // 2: decode stall holds the buffer and blocks requests
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (imem_req_valid_o) reqs++;
            chk("t2_inst", {32'b0, inst_o}, 64'h413);
            chk("t2_pco", pc_o, RPC);
        end
        chk("t2_noreq", 64'(reqs), 64'd0);
        handover();
        wait_req("t2");
        chk("t2_next", imem_addr_o, RPC + 4);

        // 3: redirect in WAIT, stale response two cycles later
        imem_req_ready_i = 1; tick(); imem_req_ready_i = 0;
        redirect_valid_i = 1; redirect_pc_i = 64'h8000_0100; tick(); redirect_valid_i = 0;
        tick();
        imem_resp_valid_i = 1; imem_resp_data_i = 32'hDEAD_BEEF; tick(); imem_resp_valid_i = 0;
        chk("t3_stale", {63'b0, inst_o == 32'hDEAD_BEEF}, 64'd0);
        wait_req("t3");
        chk("t3_addr", imem_addr_o, 64'h8000_0100);
        chk("t3_instv", {63'b0, inst_valid_o}, 64'd0);

        // 4: redirect coinciding with decode handshake
        redirect_valid_i = 1; redirect_pc_i = 64'h8000_0010; tick(); redirect_valid_i = 0;
        chk("t4_reqaddr", imem_addr_o, 64'h8000_0010);
        fetch(32'h1111_1111);
        chk("t4_pco", pc_o, 64'h8000_0010);
        inst_ready_i = 1; redirect_valid_i = 1; redirect_pc_i = 64'h8000_0040;
        tick(); clear_in();
        wait_req("t4");
        chk("t4_addr", imem_addr_o, 64'h8000_0040);

        // 5: misaligned redirect halts; then ebreak halt
        fetch(32'h2222_2222);
        redirect_valid_i = 1; redirect_pc_i = 64'h8000_0102; tick(); redirect_valid_i = 0;
        chk("t5_mis", {63'b0, misalign_o}, 64'd1);
        chk("t5_halt", {63'b0, halted_o}, 64'd1);
        reqs = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (imem_req_valid_o) reqs++;
        end
        chk("t5_noreq", 64'(reqs), 64'd0);
        do_reset();
        wait_req("t5b");
        fetch(32'h0010_0073);
        inst_ready_i = 1; halt_i = 1; tick(); clear_in();
        chk("t5_ebreak_halt", {63'b0, halted_o}, 64'd1);
        chk("t5_ebreak_instv", {63'b0, inst_valid_o}, 64'd0);
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (imem_req_valid_o) reqs++;
        end
        chk("t5_ebreak_noreq", 64'(reqs), 64'd0);

        // 6: reset mid-WAIT, late response ignored
        do_reset();
        wait_req("t6a");
        imem_req_ready_i = 1; tick(); imem_req_ready_i = 0;
        rst = 1; tick();
        chk_zero("t6");
        rst = 0;
        imem_resp_valid_i = 1; imem_resp_data_i = 32'h3333_3333; tick(); imem_resp_valid_i = 0;
        chk("t6_late_instv", {63'b0, inst_valid_o}, 64'd0);
        wait_req("t6b");
        chk("t6_addr", imem_addr_o, RPC);
        chk("t6_late_inst", {32'b0, inst_o}, 64'd0);
        fetch(32'h0000_0044);
        chk("t6_inst", {32'b0, inst_o}, 64'h44);

        // PC wrap at the top of the address space
        handover();
        wait_req("wrap_a");
        redirect_valid_i = 1; redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC; tick(); redirect_valid_i = 0;
        fetch(32'h0000_0055);
        chk("wrap_pco", pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
        handover();
        wait_req("wrap_b");
        chk("wrap_addr", imem_addr_o, 64'd0);

        // Randomized traffic: expected pc advances by 4 per consumed instruction
        // or jumps to each redirect target; memory content is a function of address.
        do_reset();
        exp_pc = RPC; pend = 0; cnt = 0; paddr = '0; handed = 0;
        for (int c = 0; c < 4000; c++) begin
            clear_in();
            busy = (pend != 0);
            if (pend != 0) begin
                if (cnt == 0) begin
                    imem_resp_valid_i = 1;
                    imem_resp_data_i = memval(paddr);
                    pend = 0;
                end else begin
                    cnt--;
                end
            end
            imem_req_ready_i = 1'($urandom_range(0, 1));
            if (imem_req_valid_o) begin
                chk("rnd_addr", imem_addr_o, exp_pc);
                if (imem_req_ready_i) begin
                    pend = 1;
                    cnt = $urandom_range(0, 2);
                    paddr = imem_addr_o;
                end
            end
            if (inst_valid_o) begin
                chk("rnd_pco", pc_o, exp_pc);
                chk("rnd_inst", {32'b0, inst_o}, {32'b0, memval(exp_pc)});
                inst_ready_i = 1'($urandom_range(0, 1));
            end
            if ((imem_req_valid_o || inst_valid_o || busy) && $urandom_range(0, 9) == 0) begin
                tgt = RPC + {50'b0, 12'($urandom_range(0, 1023)), 2'b00};
                redirect_valid_i = 1;
                redirect_pc_i = tgt;
                exp_pc = tgt;
            end else if (inst_valid_o && inst_ready_i) begin
                exp_pc = exp_pc + 4;
                handed++;
            end
            tick();
        end
        chk("rnd_progress", {63'b0, handed > 100}, 64'd1);
        chk("rnd_no_mis", {63'b0, misalign_o}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
